// File: rtl/spi_burst_master_if.sv
// Host-side strobe/data bus of the SPI burst master.
// The ctrl-code decoder (master) drives the write strobes and operands;
// the SPI shifter (slave) returns the received word and status flags.
interface spi_burst_master_if #(
    parameter int DW   = 8,
    parameter int NSS  = 2,
    parameter int DIVW = 4
);
    localparam int CW = NSS + 2 + DIVW;

    logic          WR_CTRL;
    logic [CW-1:0] CTRL_D;
    logic          WR_DATA;
    logic [DW-1:0] TX_D;
    logic [DW-1:0] RX_D;
    logic          BUSY;
    logic          DONE;
    logic          OVR;

    modport master (
        output WR_CTRL, CTRL_D, WR_DATA, TX_D,
        input  RX_D, BUSY, DONE, OVR
    );

    modport slave (
        input  WR_CTRL, CTRL_D, WR_DATA, TX_D,
        output RX_D, BUSY, DONE, OVR
    );
endinterface

// File: rtl/spi_burst_master.sv
// Hardware SPI master: shifts one DW-bit word per data write, MSB first.
// Supports one-hot slave selects, a programmable half-period divider,
// all four CPOL/CPHA modes, a one-cycle DONE pulse and a sticky overrun flag.
module spi_burst_master #(
    parameter int DW   = 8,
    parameter int NSS  = 2,
    parameter int DIVW = 4
) (
    input  logic              CLK,
    input  logic              nRESET,
    spi_burst_master_if.slave bus,
    output logic              SCK,
    output logic              MOSI,
    input  logic [NSS-1:0]    MISO,
    output logic [NSS-1:0]    nSS
);

    localparam int EW = $clog2(2 * DW);
    localparam logic [EW-1:0] ELAST = EW'(2 * DW - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Registered configuration and outputs
    logic [NSS-1:0]  nss_q;
    logic            cpol_q;
    logic            cpha_q;
    logic [DIVW-1:0] div_q;
    logic            sck_q;
    logic            mosi_q;
    logic [DW-1:0]   rx_q;
    logic            done_q;
    logic            ovr_q;

    // Shift datapath
    logic [DW-1:0]   shreg;
    logic [DIVW-1:0] hcnt;
    logic [EW-1:0]   ecnt;
    logic            rxbit;

    // Decoded ctrl word fields
    logic [NSS-1:0]  ctrl_nsel;
    logic            ctrl_cpol;
    logic            ctrl_cpha;
    logic [DIVW-1:0] ctrl_div;

    // Control strobes from the FSM
    logic ctrl_ok;
    logic start;
    logic tc;
    logic lead;
    logic last;
    logic overrun;
    logic eff_cpha;
    logic miso_eff;

    assign ctrl_nsel = bus.CTRL_D[NSS+2+DIVW-1 -: NSS];
    assign ctrl_cpol = bus.CTRL_D[DIVW+1];
    assign ctrl_cpha = bus.CTRL_D[DIVW];
    assign ctrl_div  = bus.CTRL_D[DIVW-1:0];

    // Only selected slaves contribute; no active select reads as 0
    assign miso_eff = |(MISO & ~nss_q);

    // State register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        ctrl_ok   = 1'b0;
        start     = 1'b0;
        tc        = 1'b0;
        lead      = 1'b0;
        last      = 1'b0;
        overrun   = 1'b0;
        eff_cpha  = cpha_q;
        unique case (state)
            IDLE: begin
                ctrl_ok = bus.WR_CTRL;
                start   = bus.WR_DATA;
                // A ctrl write in the same cycle takes effect for this transfer
                if (bus.WR_CTRL) begin
                    eff_cpha = ctrl_cpha;
                end
                if (bus.WR_DATA) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                overrun = bus.WR_CTRL | bus.WR_DATA;
                tc      = (hcnt == div_q);
                lead    = tc & ~ecnt[0];
                last    = tc & (ecnt == ELAST);
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration, SPI clock generation, shifting and status flags
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            nss_q  <= '1;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            div_q  <= '0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            rx_q   <= '0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            shreg  <= '0;
            hcnt   <= '0;
            ecnt   <= '0;
            rxbit  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (ctrl_ok) begin
                nss_q  <= ctrl_nsel;
                cpol_q <= ctrl_cpol;
                cpha_q <= ctrl_cpha;
                div_q  <= ctrl_div;
                sck_q  <= ctrl_cpol;
                ovr_q  <= 1'b0;
            end

            if (overrun) begin
                ovr_q <= 1'b1;
            end

            if (start) begin
                shreg <= bus.TX_D;
                hcnt  <= '0;
                ecnt  <= '0;
                if (!eff_cpha) begin
                    mosi_q <= bus.TX_D[DW-1];
                end
            end

            if (state == SHIFT) begin
                if (tc) begin
                    hcnt  <= '0;
                    ecnt  <= ecnt + 1'b1;
                    sck_q <= ~sck_q;
                    if (lead) begin
                        if (!cpha_q) begin
                            rxbit <= miso_eff;
                        end else begin
                            mosi_q <= shreg[DW-1];
                        end
                    end else begin
                        // cpha=0 holds the leading-edge sample in rxbit until the
                        // trailing shift so the untransmitted LSBs are not clobbered
                        if (!cpha_q) begin
                            shreg <= {shreg[DW-2:0], rxbit};
                            if (!last) begin
                                mosi_q <= shreg[DW-2];
                            end
                        end else begin
                            shreg <= {shreg[DW-2:0], miso_eff};
                        end
                    end
                    if (last) begin
                        rx_q   <= cpha_q ? {shreg[DW-2:0], miso_eff}
                                         : {shreg[DW-2:0], rxbit};
                        done_q <= 1'b1;
                    end
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign nSS      = nss_q;
    assign bus.RX_D = rx_q;
    assign bus.BUSY = (state == SHIFT);
    assign bus.DONE = done_q;
    assign bus.OVR  = ovr_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Scoreboard bench for spi_burst_master (DW=8, NSS=2, DIVW=4).
// Stimulus pushes the expected received word and DONE cycle; a monitor pops
// on every DONE pulse. The monitor also logs SCK toggles and acts as a mode-3
// serial slave when enabled.
module tb_spi_burst_master;

    typedef struct {
        logic [7:0] rx;
        int         t;
    } exp_t;

    typedef struct {
        int   t;
        logic sck;
        logic mosi;
    } tog_t;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       SCK;
    logic       MOSI;
    logic [1:0] MISO;
    logic [1:0] nSS;

    logic       loop = 1'b0;
    logic [1:0] miso_drv = 2'b00;
    logic       slv_en = 1'b0;
    logic       slv_bit = 1'b0;
    logic [7:0] slv_pat = 8'h00;
    int         slv_idx = 0;
    logic       cur_cpol = 1'b0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    tog_t tlog[$];

    spi_burst_master_if #(.DW(8), .NSS(2), .DIVW(4)) bus ();

    spi_burst_master #(.DW(8), .NSS(2), .DIVW(4)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus),
        .SCK    (SCK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .nSS    (nSS)
    );

    assign MISO = loop ? {1'b0, MOSI} : (slv_en ? {slv_bit, miso_drv[0]} : miso_drv);

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard on DONE, SCK toggle log, serial slave
    initial begin : monitor
        logic sck_prev;
        exp_t e;
        sck_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (SCK !== sck_prev) begin
                tlog.push_back('{t: cyc, sck: SCK, mosi: MOSI});
                if (slv_en && SCK != cur_cpol && slv_idx < 8) begin
                    slv_bit = slv_pat[7-slv_idx];
                    slv_idx++;
                end
            end
            sck_prev = SCK;
            if (bus.DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rx_word", {24'd0, bus.RX_D}, {24'd0, e.rx});
                    chk("done_cycle", cyc, e.t);
                end
            end
        end
    end

    task automatic wr_ctrl(input logic [1:0] nsel, input logic cpol, input logic cpha,
                           input logic [3:0] div);
        bus.CTRL_D  = {nsel, cpol, cpha, div};
        bus.WR_CTRL = 1'b1;
        cur_cpol    = cpol;
        @(negedge CLK);
        bus.WR_CTRL = 1'b0;
    endtask

    // Start a transfer (optionally with a same-cycle ctrl write); returns edge k
    task automatic issue(input logic [7:0] tx, input logic [7:0] exp_rx, input int h,
                         input logic do_ctrl, input logic [7:0] ctrl, output int k);
        if (do_ctrl) begin
            bus.CTRL_D  = ctrl;
            bus.WR_CTRL = 1'b1;
            cur_cpol    = ctrl[5];
        end
        bus.TX_D    = tx;
        bus.WR_DATA = 1'b1;
        k = cyc + 1;
        tlog.delete();
        sb.push_back('{rx: exp_rx, t: k + 16 * h});
        @(negedge CLK);
        bus.WR_DATA = 1'b0;
        bus.WR_CTRL = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.BUSY === 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("busy_timeout", {31'd0, bus.BUSY}, 32'd0);
        @(negedge CLK);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic check_toggles(input int k, input int h, input logic [7:0] exp_mosi);
        int cnt, first, lst, prev, badsp, nb;
        logic [7:0] bits;
        cnt = 0; first = -1; lst = -1; prev = -1; badsp = 0; nb = 0; bits = '0;
        foreach (tlog[i]) begin
            if (tlog[i].t > k) begin
                if (cnt == 0) first = tlog[i].t;
                else if (tlog[i].t - prev != h) badsp++;
                prev = tlog[i].t;
                lst  = tlog[i].t;
                cnt++;
                if (tlog[i].sck != cur_cpol && nb < 8) begin
                    bits = {bits[6:0], tlog[i].mosi};
                    nb++;
                end
            end
        end
        chk("tog_count", cnt, 32'd16);
        chk("tog_first", first, k + h);
        chk("tog_spacing", badsp, 32'd0);
        chk("tog_last", lst, k + 16 * h);
        chk("mosi_bits", {24'd0, bits}, {24'd0, exp_mosi});
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        bus.WR_CTRL = 1'b0;
        bus.CTRL_D  = '0;
        bus.WR_DATA = 1'b0;
        bus.TX_D    = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_sck", {31'd0, SCK}, 32'd0);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_nss", {30'd0, nSS}, 32'd3);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst_done", {31'd0, bus.DONE}, 32'd0);
        chk("rst_ovr", {31'd0, bus.OVR}, 32'd0);
        chk("rst_rx", {24'd0, bus.RX_D}, 32'd0);
        nRESET = 1'b1;
        @(negedge CLK);

        // Mode 0, div=0, loopback on MISO[0]
        loop = 1'b1;
        wr_ctrl(2'b10, 1'b0, 1'b0, 4'd0);
        issue(8'hA5, 8'hA5, 1, 1'b0, 8'h00, k);
        chk("t1_busy", {31'd0, bus.BUSY}, 32'd1);
        chk("t1_mosi_first", {31'd0, MOSI}, 32'd1);
        wait_idle(100);
        check_toggles(k, 1, 8'hA5);
        chk("t1_nss", {30'd0, nSS}, 32'd2);
        chk("t1_mosi_hold", {31'd0, MOSI}, 32'd1);
        chk("t1_sck_idle", {31'd0, SCK}, 32'd0);

        // Mode 3, div=3, slave on MISO[1] sends 8'h3C; MISO[0]=1 is deselected
        loop = 1'b0;
        miso_drv = 2'b01;
        wr_ctrl(2'b01, 1'b1, 1'b1, 4'd3);
        chk("t2_sck_idle_hi", {31'd0, SCK}, 32'd1);
        slv_pat = 8'h3C;
        slv_idx = 0;
        slv_bit = 1'b0;
        slv_en  = 1'b1;
        issue(8'h5A, 8'h3C, 4, 1'b0, 8'h00, k);
        wait_idle(200);
        check_toggles(k, 4, 8'h5A);
        chk("t2_sck_end", {31'd0, SCK}, 32'd1);
        slv_en = 1'b0;

        // Overrun: WR_DATA at k+5 while busy
        loop = 1'b1;
        wr_ctrl(2'b10, 1'b0, 1'b0, 4'd0);
        issue(8'hC3, 8'hC3, 1, 1'b0, 8'h00, k);
        repeat (4) @(negedge CLK);
        bus.TX_D    = 8'hFF;
        bus.WR_DATA = 1'b1;
        @(negedge CLK);
        bus.WR_DATA = 1'b0;
        chk("t3_ovr_set", {31'd0, bus.OVR}, 32'd1);
        chk("t3_still_busy", {31'd0, bus.BUSY}, 32'd1);
        wait_idle(100);
        check_toggles(k, 1, 8'hC3);
        chk("t3_ovr_sticky", {31'd0, bus.OVR}, 32'd1);
        wr_ctrl(2'b10, 1'b0, 1'b0, 4'd0);
        chk("t3_ovr_clear", {31'd0, bus.OVR}, 32'd0);

        // Simultaneous ctrl (div=1, cpol=1) and data; ctrl on the DONE edge is busy
        issue(8'hFF, 8'hFF, 2, 1'b1, {2'b10, 1'b1, 1'b0, 4'd1}, k);
        chk("t4_sck_pre", {31'd0, SCK}, 32'd1);
        repeat (31) @(negedge CLK);
        bus.CTRL_D  = {2'b11, 1'b0, 1'b0, 4'd0};
        bus.WR_CTRL = 1'b1;
        @(negedge CLK);
        bus.WR_CTRL = 1'b0;
        chk("t4_idle_at_done", {31'd0, bus.BUSY}, 32'd0);
        chk("t4_ovr_done_edge", {31'd0, bus.OVR}, 32'd1);
        chk("t4_nss_kept", {30'd0, nSS}, 32'd2);
        chk("t4_sck_end", {31'd0, SCK}, 32'd1);
        @(negedge CLK);
        chk("t4_sb_drained", sb.size(), 32'd0);
        check_toggles(k, 2, 8'hFF);

        // Asynchronous reset at k+7 of a transfer
        wr_ctrl(2'b10, 1'b0, 1'b0, 4'd0);
        issue(8'h5A, 8'h5A, 1, 1'b0, 8'h00, k);
        repeat (7) @(negedge CLK);
        nRESET = 1'b0;
        #1;
        chk("t5_sck", {31'd0, SCK}, 32'd0);
        chk("t5_nss", {30'd0, nSS}, 32'd3);
        chk("t5_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("t5_rx", {24'd0, bus.RX_D}, 32'd0);
        chk("t5_mosi", {31'd0, MOSI}, 32'd0);
        sb.delete();
        cur_cpol = 1'b0;
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        wr_ctrl(2'b10, 1'b0, 1'b0, 4'd0);
        issue(8'h81, 8'h81, 1, 1'b0, 8'h00, k);
        wait_idle(100);
        check_toggles(k, 1, 8'h81);

        // No select active, MISO all ones
        loop = 1'b0;
        miso_drv = 2'b11;
        wr_ctrl(2'b11, 1'b0, 1'b0, 4'd0);
        issue(8'h5A, 8'h00, 1, 1'b0, 8'h00, k);
        wait_idle(100);
        check_toggles(k, 1, 8'h5A);
        chk("t6_mosi_hold", {31'd0, MOSI}, 32'd0);

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
